// File: rtl/sdram_pll_reset_sequencer.sv
// Pulses the SDRAM PLL reset, waits for a stable synchronized lock, then releases
// a lock-qualified system reset; re-runs the sequence on lock timeout or loss.
module sdram_pll_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_count,
  output logic [1:0] seq_state
);

  localparam int unsigned MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, locked_s;
  logic [7:0]       retry_d;
  logic             pll_rst_d, sys_rst_d, ready_d, lock_lost_d;
  logic             retry_bump;

  // Next state, counter and registered-output values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_bump  = 1'b0;
    lock_lost_d = 1'b0;
    retry_d     = retry_count;

    case (state_q)
      PLL_RESET: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABILIZE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d    = PLL_RESET;
          retry_bump = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABILIZE: begin
        // A lock drop wins over the terminal count
        if (!locked_s)                  state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST)  state_d = RUN;
        else                            cnt_d   = cnt_q + CNT_W'(1);
      end
      RUN: begin
        if (!locked_s) begin
          state_d     = PLL_RESET;
          retry_bump  = 1'b1;
          lock_lost_d = 1'b1;
        end
      end
      default: state_d = PLL_RESET;
    endcase

    if (state_d != state_q) cnt_d = '0;
    if (retry_bump && (retry_count != 8'hFF)) retry_d = retry_count + 8'd1;

    pll_rst_d = (state_d == PLL_RESET);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  // State, counter, synchronizer and output registers
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= PLL_RESET;
      cnt_q       <= '0;
      sync1_q     <= 1'b0;
      locked_s    <= 1'b0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync1_q     <= locked;
      locked_s    <= sync1_q;
      pll_rst     <= pll_rst_d;
      sys_rst     <= sys_rst_d;
      ready       <= ready_d;
      lock_lost   <= lock_lost_d;
      retry_count <= retry_d;
    end
  end

  assign seq_state = state_q;

endmodule

// File: tb/tb_sdram_pll_reset_sequencer.sv
// Self-checking bench: directed scenarios plus random lock/reset activity, compared
// every cycle against a countdown-based behavioural model of the sequencer.
module tb_sdram_pll_reset_sequencer;

  localparam int unsigned RP = 4;
  localparam int unsigned TO = 32;
  localparam int unsigned ST = 8;

  logic       refclk = 1'b0;
  logic       rst    = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst, sys_rst, ready, lock_lost;
  logic [7:0] retry_count;
  logic [1:0] seq_state;

  int checks = 0;
  int errors = 0;

  // Reference model: phase number, cycles left in the current window, lock delay line
  int m_phase, m_left, m_retry;
  bit m_lost, m_d1, m_d2;

  sdram_pll_reset_sequencer #(
    .RST_PULSE_CYCLES   (RP),
    .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES (ST)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked     (locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .retry_count(retry_count),
    .seq_state  (seq_state)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    bit ls;
    if (rst) begin
      m_phase = 0; m_left = RP; m_retry = 0; m_lost = 0; m_d1 = 0; m_d2 = 0;
    end else begin
      ls     = m_d2;
      m_lost = 0;
      case (m_phase)
        0: begin
          m_left--;
          if (m_left == 0) begin m_phase = 1; m_left = TO; end
        end
        1: begin
          if (ls) begin
            m_phase = 2; m_left = ST;
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_phase = 0; m_left = RP;
              m_retry = (m_retry < 255) ? m_retry + 1 : 255;
            end
          end
        end
        2: begin
          if (!ls) begin
            m_phase = 1; m_left = TO;
          end else begin
            m_left--;
            if (m_left == 0) m_phase = 3;
          end
        end
        default: begin
          if (!ls) begin
            m_phase = 0; m_left = RP; m_lost = 1;
            m_retry = (m_retry < 255) ? m_retry + 1 : 255;
          end
        end
      endcase
      m_d2 = m_d1;
      m_d1 = locked;
    end
  endtask

  // One clock: advance the model with the inputs the DUT sampled, then compare
  task automatic tick();
    @(posedge refclk);
    model_step();
    #1;
    check("seq_state",   32'(seq_state),   32'(m_phase));
    check("pll_rst",     32'(pll_rst),     32'(m_phase == 0));
    check("sys_rst",     32'(sys_rst),     32'(m_phase != 3));
    check("ready",       32'(ready),       32'(m_phase == 3));
    check("lock_lost",   32'(lock_lost),   32'(m_lost));
    check("retry_count", 32'(retry_count), 32'(m_retry));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Ticks until sys_rst equals val; returns the tick count (limit on expiry)
  task automatic until_sys_rst(input logic val, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      tick(); n++;
      if (sys_rst === val) break;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(seq_state),   32'd0);
    check({tag, "_pll"},   32'(pll_rst),     32'd1);
    check({tag, "_sys"},   32'(sys_rst),     32'd1);
    check({tag, "_ready"}, 32'(ready),       32'd0);
    check({tag, "_lost"},  32'(lock_lost),   32'd0);
    check({tag, "_retry"}, 32'(retry_count), 32'd0);
  endtask

  initial begin
    int n, r0, hold;
    bit prev, saw_wait, saw_lost;

    // 1: power-up and clean lock
    rst = 1'b1; locked = 1'b0;
    ticks(3);
    check_reset_values("t1_rst");
    rst = 1'b0;
    n = 0;
    while (n < 20) begin tick(); n++; if (pll_rst === 1'b0) break; end
    check("t1_pll_pulse_len", 32'(n), 32'(RP));
    ticks(10);
    locked = 1'b1;
    until_sys_rst(1'b0, 60, n);
    check("t1_release_latency", 32'(n), 32'(2 + 1 + ST));
    check("t1_retry", 32'(retry_count), 32'd0);
    check("t1_state", 32'(seq_state), 32'd3);

    // 2: lock never arrives
    locked = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      n = 0; prev = pll_rst;
      while (n < 100) begin
        tick(); n++;
        if (!prev && pll_rst) break;
        prev = pll_rst;
      end
      check("t2_retry_period", 32'(n), 32'(RP + TO));
      check("t2_retry_count", 32'(retry_count), 32'(k));
      check("t2_sys_rst", 32'(sys_rst), 32'd1);
    end

    // 3: one-cycle glitch at stabilize count 5
    locked = 1'b1;
    n = 0;
    while (n < 100 && !(m_phase == 2 && m_left == ST - 5)) begin tick(); n++; end
    check("t3_reach_stab5", 32'(m_phase == 2 && m_left == ST - 5), 32'd1);
    r0 = m_retry;
    locked = 1'b0; tick(); locked = 1'b1;
    saw_wait = 0; saw_lost = 0; n = 0;
    while (n < 60) begin
      tick(); n++;
      if (seq_state === 2'd1) saw_wait = 1;
      if (lock_lost === 1'b1) saw_lost = 1;
      if (sys_rst === 1'b0) break;
    end
    check("t3_release_after_rerise", 32'(n), 32'(2 + 1 + ST));
    check("t3_saw_wait_lock", 32'(saw_wait), 32'd1);
    check("t3_no_lock_lost", 32'(saw_lost), 32'd0);
    check("t3_no_retry", 32'(retry_count), 32'(r0));

    // 4: loss in RUN
    ticks(5);
    r0 = m_retry;
    locked = 1'b0;
    n = 0;
    while (n < 10) begin tick(); n++; if (lock_lost === 1'b1) break; end
    check("t4_loss_latency", 32'(n), 32'd3);
    check("t4_sys_rst", 32'(sys_rst), 32'd1);
    check("t4_pll_rst", 32'(pll_rst), 32'd1);
    check("t4_retry_inc", 32'(retry_count), 32'(r0 + 1));
    tick();
    check("t4_lost_one_cycle", 32'(lock_lost), 32'd0);
    locked = 1'b1;
    until_sys_rst(1'b0, 200, n);
    check("t4_rerun_state", 32'(seq_state), 32'd3);

    // 5: saturation after 300 timeouts
    locked = 1'b0;
    ticks(300 * (RP + TO) + 50);
    check("t5_retry_sat", 32'(retry_count), 32'd255);

    // 6: reset mid-STABILIZE, then mid-RUN
    locked = 1'b1;
    n = 0;
    while (n < 100 && m_phase != 2) begin tick(); n++; end
    ticks(2);
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset_values("t6_stab");
    n = 0;
    while (n < 100 && m_phase != 3) begin tick(); n++; end
    check("t6_reach_run", 32'(seq_state), 32'd3);
    ticks(3);
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset_values("t6_run");

    // Random lock activity with occasional resets
    n = 0;
    while (n < 3000) begin
      locked = 1'($urandom_range(0, 1));
      hold   = int'($urandom_range(1, 60));
      for (int i = 0; i < hold; i++) begin
        rst = ($urandom_range(0, 59) == 0);
        tick(); n++;
      end
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
